// File: rtl/lut_bist.sv
// Stimulus/response BIST for a 3-input combinational block: walks {a,b,c} through
// 0..7, samples f_in after a settle delay and checks it against the EXPECTED table.
module lut_bist #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail,
    output logic       first_fail_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t     state, state_nx;
    logic [2:0] idx;
    logic [2:0] stim;
    logic [3:0] cnt;
    logic       mismatch;
    logic       do_clear, do_count, do_sample, do_finish;

    assign mismatch = (f_in != EXPECTED[idx]);
    assign {a_out, b_out, c_out} = stim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WAIT;
            WAIT:    if (cnt == 4'(SETTLE - 1)) state_nx = SAMPLE;
            SAMPLE:  state_nx = (idx == 3'd7) ? DONE : WAIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state strobes steering the registered datapath below.
    always_comb begin
        do_clear  = 1'b0;
        do_count  = 1'b0;
        do_sample = 1'b0;
        do_finish = 1'b0;
        case (state)
            IDLE:    do_clear  = start;
            WAIT:    do_count  = 1'b1;
            SAMPLE:  do_sample = 1'b1;
            DONE:    do_finish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            stim             <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            captured         <= '0;
            fail_count       <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (do_clear) begin
                idx              <= '0;
                stim             <= '0;
                cnt              <= '0;
                busy             <= 1'b1;
                pass             <= 1'b0;
                captured         <= '0;
                fail_count       <= '0;
                first_fail       <= '0;
                first_fail_valid <= 1'b0;
            end
            if (do_count) cnt <= cnt + 4'd1;
            if (do_sample) begin
                captured[idx] <= f_in;
                if (mismatch) begin
                    fail_count <= fail_count + 4'd1;
                    if (!first_fail_valid) begin
                        first_fail       <= idx;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (idx == 3'd7) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    // Final count includes the vector being sampled now.
                    pass <= ((fail_count + 4'(mismatch)) == 4'd0);
                end else begin
                    idx  <= idx + 3'd1;
                    stim <= idx + 3'd1;
                    cnt  <= '0;
                end
            end
            if (do_finish) begin
                done <= 1'b0;
                stim <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lut_bist.sv
// Directed bench for lut_bist: majority-function block model with fault modes,
// result table, timing/stimulus checks, re-start, back-to-back and reset-abort runs.
module tb_lut_bist;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       f_in;
    logic       a_out, b_out, c_out, busy, done, pass, first_fail_valid;
    logic [7:0] captured;
    logic [3:0] fail_count;
    logic [2:0] first_fail;

    int total = 0;
    int bad = 0;
    int mode = 0;  // 0 majority, 1 majority inverted at 5, 2 stuck 0, 3 stuck 1

    lut_bist #(.SETTLE(2), .EXPECTED(8'hE8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .busy(busy), .done(done), .pass(pass), .captured(captured),
        .fail_count(fail_count), .first_fail(first_fail),
        .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;

    // Block under test model
    always_comb begin
        logic m;
        m = (a_out & b_out) | (a_out & c_out) | (b_out & c_out);
        case (mode)
            1:       f_in = ({a_out, b_out, c_out} == 3'd5) ? ~m : m;
            2:       f_in = 1'b0;
            3:       f_in = 1'b1;
            default: f_in = m;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         mode;
        logic [7:0] cap;
        logic       pass;
        logic [3:0] fc;
        logic [2:0] ff;
        logic       ffv;
        bit         restart;
    } vec_t;

    vec_t tbl[5];

    // Caller is at a negedge. Starts a run and checks timing, stimulus and busy.
    task automatic run(input bit restart);
        int  n;
        int  done_at;
        bit  stim_ok;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        done_at = -1;
        stim_ok = ({a_out, b_out, c_out} == 3'd0) && busy && !done;
        while (n < 40 && done_at < 0) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (restart && n == 10);
            if (done) done_at = n;
            else if ({a_out, b_out, c_out} != 3'(n / 3) || !busy) stim_ok = 1'b0;
        end
        start = 1'b0;
        chk("done_latency", 32'(done_at), 32'd24);
        chk("stim_busy_seq", {31'b0, stim_ok}, 32'd1);
        chk("busy_fall", {31'b0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("stim_return", {29'b0, a_out, b_out, c_out}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) begin
                chk("idle_quiet", {30'b0, done, busy}, 32'd0);
            end
        end
    endtask

    task automatic chk_results(input vec_t v);
        chk("captured", {24'b0, captured}, {24'b0, v.cap});
        chk("pass", {31'b0, pass}, {31'b0, v.pass});
        chk("fail_count", {28'b0, fail_count}, {28'b0, v.fc});
        chk("first_fail_valid", {31'b0, first_fail_valid}, {31'b0, v.ffv});
        if (v.ffv) chk("first_fail", {29'b0, first_fail}, {29'b0, v.ff});
    endtask

    initial begin
        int d1, d2, n;
        tbl[0] = '{0, 8'hE8, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1, 8'hC8, 1'b0, 4'd1, 3'd5, 1'b1, 1'b0};
        tbl[2] = '{2, 8'h00, 1'b0, 4'd4, 3'd3, 1'b1, 1'b0};
        tbl[3] = '{3, 8'hFF, 1'b0, 4'd4, 3'd0, 1'b1, 1'b0};
        tbl[4] = '{0, 8'hE8, 1'b1, 4'd0, 3'd0, 1'b0, 1'b1};

        #1;
        chk("reset_outputs", {a_out, b_out, c_out, busy, done, pass, captured,
                              fail_count, first_fail, first_fail_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run(tbl[i].restart);
            chk_results(tbl[i]);
        end

        // Back-to-back runs with start held high
        mode = 0;
        d1 = -1;
        d2 = -1;
        n = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        while (n < 80 && d2 < 0) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd24);
        chk("b2b_spacing", 32'(d2 - d1), 32'd26);
        repeat (4) @(negedge clk);

        // Reset while vector 4 is driven
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset_vec", {29'b0, a_out, b_out, c_out}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {a_out, b_out, c_out, busy, done, pass, captured,
                              fail_count, first_fail, first_fail_valid}, 32'd0);
        d1 = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) d1++;
        end
        chk("abort_no_done", 32'(d1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 1;
        run(1'b0);
        chk_results(tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lut_bist.md
# lut_bist

Self-checking stimulus/response engine for 3-input combinational blocks such as the course LUT exercises. On `start` it drives all eight `{a,b,c}` combinations in ascending order and waits a programmable settle time after each. It then samples the block's output `f_in`, assembles the observed truth table, and compares it bit-by-bit against a parameterised expected table. This is the synthesizable on-board counterpart of the simulation stimulus loop: it drives the block from the other side and reports pass/fail to LEDs or a status register.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `EXPECTED`, default 8'hE8: expected truth table; bit `i` is the expected `F` for `{a,b,c} = i`. The default is the 3-input majority function.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `f_in`  in  1  output of the block under test.
- `a_out`, `b_out`, `c_out`  out  1 each  stimulus; `{a_out,b_out,c_out}` = vector index, with `a_out` as MSB.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last run had zero mismatches.
- `captured`  out  8  observed truth table; bit `i` = `f_in` sampled for vector `i`.
- `fail_count`  out  4  number of mismatching vectors, 0..8.
- `first_fail`  out  3  index of the lowest mismatching vector.
- `first_fail_valid`  out  1  `first_fail` is meaningful.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE with `start`=1:
  - Clear `captured`, `fail_count`, `first_fail`, `first_fail_valid`, `pass`.
  - Set `idx`=0, stimulus=3'b000, settle counter=0, `busy`=1.
  - Go to WAIT.
- WAIT: increment the settle counter. When it equals `SETTLE`-1, go to SAMPLE. The stimulus holds constant.
- SAMPLE:
  - Write `captured[idx]` <= `f_in`.
  - If `f_in` != `EXPECTED[idx]`, increment `fail_count`.
  - If this is the first mismatch of the run, load `first_fail`<=`idx` and `first_fail_valid`<=1.
  - If `idx`==7: go to DONE and set `busy`<=0, `done`<=1, `pass` <= (final mismatch count == 0). The count includes the current vector.
  - Otherwise: `idx`<=`idx`+1, stimulus<=`idx`+1, clear the settle counter, and go to WAIT.
- DONE: `done`<=0, stimulus<=3'b000, return to IDLE.
- `start` is ignored in WAIT, SAMPLE and DONE. A new run requires `start` in IDLE.
- Results (`captured`, `pass`, `fail_count`, `first_fail*`) hold until the next accepted `start`.
- `fail_count` is 4 bits wide, so 8 mismatches are representable and no saturation logic is needed.
- All outputs are registered. No combinational path exists from `f_in` to any output.

## Timing
- Reset values: all outputs 0, state IDLE, `idx`=0.
- Reset asserted mid-run aborts immediately:
  - All outputs go to 0.
  - No `done` pulse is issued.
  - Results are lost.
- Let E0 be the edge that accepts `start`. Vector k is driven from E(k·(SETTLE+1)) and sampled at E((k+1)·(SETTLE+1)).
- Each vector is held stable for exactly `SETTLE`+1 cycles.
- With `SETTLE`=2:
  - Vector 7 is sampled at E24.
  - `done` is high for the cycle after E24.
  - `busy` falls at E24.
  - The FSM is back in IDLE after E25.
- A `start` held continuously high starts a new run at E26. IDLE is entered at E25, and `start` is sampled there on the following edge, E26.

## Test plan
- Bench models majority and drives it from `a/b/c_out`; `SETTLE`=2, pulse `start`. Required: `done` pulses the cycle after E24, `captured`=8'hE8, `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- Bench majority with output inverted only for `{a,b,c}`=5. Required: `captured`=8'hC8, `pass`=0, `fail_count`=1, `first_fail`=5, `first_fail_valid`=1.
- `f_in` stuck at 0. Required: `captured`=8'h00, `fail_count`=4, `first_fail`=3, `pass`=0. Then `f_in` stuck at 1: `captured`=8'hFF, `fail_count`=4, `first_fail`=0.
- Stimulus check: stimulus steps 0..7 in order; each value is held exactly 3 cycles; `busy` is high throughout; the stimulus returns to 000 after DONE.
- `start` pulsed again during vector 3. Required: the pulse is ignored, there is a single `done`, and timing is unchanged. `start` held high continuously produces back-to-back runs with `done` pulses 26 cycles apart.
- Drop `rst_n` while vector 4 is driven. Required: all outputs read 0 immediately, with no `done`. After release, a new `start` completes a full run with the correct results.
